// File: rtl/mult_div_pkg.sv
// Shared state encoding and opcode constants for the iterative HI/LO multiply/divide path.
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIXUP,
    DONE
  } state_t;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_MULT = 1'b1;
  localparam int   ITER    = 32;

endpackage

// File: rtl/md_step.sv
// One unsigned iteration: right-shifting shift-add multiply or restoring divide step.
// Combinational; the quotient bit is returned separately and merged by the caller.
module md_step
  import mult_div_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic               op,
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH:0]     operand,
  output logic [2*WIDTH:0]   accNext,
  output logic               qBit
);

  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   shiftedRem;
  logic [WIDTH:0]   diff;

  // MULT keeps {partial product, remaining multiplier}; DIV keeps {remainder, dividend/quotient}.
  always_comb begin
    sum        = {1'b0, acc[2*WIDTH:WIDTH]} + {1'b0, (acc[0] ? operand : '0)};
    shiftedRem = acc[2*WIDTH-1:WIDTH-1];
    diff       = shiftedRem - operand;
    accNext    = '0;
    qBit       = 1'b0;
    if (op == OP_MULT) begin
      accNext = {sum, acc[WIDTH-1:1]};
    end else begin
      qBit    = (shiftedRem >= operand);
      accNext = {(qBit ? diff : shiftedRem), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed MULT/DIV sequencer producing HI/LO: IDLE -> RUN x WIDTH -> FIXUP -> DONE.
// Optional `UNSIGNED_OPS_EN adds is_unsigned (MULTU/DIVU); latency is identical either way.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef UNSIGNED_OPS_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_we,
  output logic             lo_we
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic             opQ;
  logic             negQ;
  logic             remNegQ;
  logic [WIDTH:0]   divisor;
  logic [2*WIDTH:0] acc;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH:0] stepAcc;
  logic             stepQ;
  logic             isUns;
  logic             aNeg;
  logic             bNeg;
  logic [WIDTH:0]   aMag;
  logic [WIDTH:0]   bMag;

`ifdef UNSIGNED_OPS_EN
  assign isUns = is_unsigned;
`else
  assign isUns = 1'b0;
`endif

  // Magnitudes carry an extra bit so |most-negative| stays a plain unsigned 2^(WIDTH-1).
  assign aNeg = a_in[WIDTH-1] & ~isUns;
  assign bNeg = b_in[WIDTH-1] & ~isUns;
  assign aMag = aNeg ? {1'b0, -a_in} : {1'b0, a_in};
  assign bMag = bNeg ? {1'b0, -b_in} : {1'b0, b_in};

  md_step #(.WIDTH(WIDTH)) uStep (
    .op      (opQ),
    .acc     (acc),
    .operand (divisor),
    .accNext (stepAcc),
    .qBit    (stepQ)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_we    <= 1'b0;
      lo_we    <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      acc      <= '0;
      divisor  <= '0;
      cnt      <= '0;
      opQ      <= 1'b0;
      negQ     <= 1'b0;
      remNegQ  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_we    <= 1'b0;
      lo_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opQ     <= op;
            negQ    <= aNeg ^ bNeg;
            remNegQ <= aNeg;
            cnt     <= '0;
            busy    <= 1'b1;
            acc     <= {{(WIDTH+1){1'b0}}, (op == OP_MULT) ? bMag[WIDTH-1:0] : aMag[WIDTH-1:0]};
            divisor <= (op == OP_MULT) ? aMag : bMag;
            if (op == OP_DIV && b_in == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= {stepAcc[2*WIDTH:1], (opQ == OP_MULT) ? stepAcc[0] : stepQ};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIXUP;
        end
        FIXUP: begin
          if (opQ == OP_MULT) begin
            {hi_out, lo_out} <= negQ ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
          end else begin
            lo_out <= negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi_out <= remNegQ ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end
          state <= DONE;
          done  <= 1'b1;
          hi_we <= 1'b1;
          lo_we <= 1'b1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Table-driven plus scoreboard bench for mult_div_seq, with hand sequences for abort and ignored start.
module tb_mult_div_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
`ifdef UNSIGNED_OPS_EN
  logic        is_unsigned;
`endif
  logic        busy, done, div_zero, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;

  mult_div_seq #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
`ifdef UNSIGNED_OPS_EN
    .is_unsigned(is_unsigned),
`endif
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .hi_we    (hi_we),
    .lo_we    (lo_we)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];
  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t model(input logic mop, input logic uns, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    longint          sa, sbv, sp;
    longint unsigned ua, ub, up;
    v.op = mop; v.uns = uns; v.a = a; v.b = b; v.dz = 1'b0;
    sa = longint'($signed(a)); sbv = longint'($signed(b));
    ua = {32'b0, a};           ub = {32'b0, b};
    if (mop) begin
      if (uns) begin up = ua * ub; v.hi = up[63:32]; v.lo = up[31:0]; end
      else     begin sp = sa * sbv; v.hi = sp[63:32]; v.lo = sp[31:0]; end
    end else begin
      if (uns) begin up = ua / ub; v.lo = up[31:0]; up = ua % ub; v.hi = up[31:0]; end
      else     begin sp = sa / sbv; v.lo = sp[31:0]; sp = sa % sbv; v.hi = sp[31:0]; end
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic mop, input logic uns, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    vec_t v;
    v.op = mop; v.uns = uns; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz;
    return v;
  endfunction

  // Drives start for cycle 0, then scrambles operands; returns in cycle 1.
  task automatic launch(input vec_t v);
    start = 1'b1; op = v.op; a_in = v.a; b_in = v.b;
`ifdef UNSIGNED_OPS_EN
    is_unsigned = v.uns;
`endif
    tick();
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
  endtask

  task automatic issue(input vec_t v);
    sb.push_back(v);
    launch(v);
  endtask

  task automatic finishOp(input int startCyc);
    int   n;
    logic gap;
    vec_t e;
    n   = startCyc;
    gap = 1'b0;
    while (!done && n < 80) begin
      if (!busy) gap = 1'b1;
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected a pending result");
    end else begin
      e = sb.pop_front();
      check("latency", 64'(n), e.dz ? 64'd1 : 64'd34);
      check("busy_held", {63'b0, gap}, 64'd0);
      check("busy_at_done", {63'b0, busy}, 64'd1);
      check("hi_out", {32'b0, hi_out}, {32'b0, e.hi});
      check("lo_out", {32'b0, lo_out}, {32'b0, e.lo});
      check("we_dz", {61'b0, hi_we, lo_we, div_zero}, {61'b0, ~e.dz, ~e.dz, e.dz});
    end
    tick();
    check("after_done", {60'b0, done, hi_we, lo_we, busy}, 64'd0);
  endtask

  initial begin
    vec_t v;
    logic sawDone;
    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
`ifdef UNSIGNED_OPS_EN
    is_unsigned = 1'b0;
`endif
    tick(); tick();
    check("reset_ctrl", {59'b0, busy, done, div_zero, hi_we, lo_we}, 64'd0);
    check("reset_hilo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0;
    tick();

    tbl.push_back(mk(1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h451,      32'h20,       32'h11,       32'h22,       1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'd5,        32'd0,        32'h11,       32'h22,       1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 32'd0,        32'h12345678, 32'h0,        32'h0,        1'b0));
`ifdef UNSIGNED_OPS_EN
    tbl.push_back(mk(1'b1, 1'b1, 32'hFFFFFFFF, 32'd2,        32'h1,        32'hFFFFFFFE, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,        32'h1,        32'h7FFFFFFF, 1'b0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i]);
      finishOp(1);
    end

    for (int i = 0; i < 6; i++) begin
      logic [31:0] rb;
      rb = $urandom;
      if (rb == 0) rb = 32'd13;
      v = model(i[0], 1'b0, $urandom, rb);
      issue(v);
      finishOp(1);
    end

    // A start pulse mid-operation must not disturb the running divide.
    v = model(1'b0, 1'b0, 32'd1000, 32'd3);
    issue(v);
    repeat (4) tick();
    start = 1'b1; op = 1'b1; a_in = 32'd9; b_in = 32'd9;
    tick();
    start = 1'b0;
    finishOp(6);

    // Reset mid-operation aborts silently and clears the results.
    launch(mk(1'b0, 1'b0, 32'd77, 32'd5, 32'd0, 32'd0, 1'b0));
    repeat (4) tick();
    start = 1'b1; op = 1'b1; a_in = 32'd6; b_in = 32'd6;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hilo", {hi_out, lo_out}, 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || hi_we || lo_we) sawDone = 1'b1;
      tick();
    end
    check("abort_no_done", {63'b0, sawDone}, 64'd0);

    reset = 1'b1; start = 1'b1; op = 1'b1; a_in = 32'd2; b_in = 32'd2;
    tick();
    reset = 1'b0; start = 1'b0;
    check("reset_prio_busy", {63'b0, busy}, 64'd0);
    tick();
    check("reset_prio_idle", {63'b0, busy}, 64'd0);

    issue(mk(1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0));
    finishOp(1);
    repeat (5) tick();
    check("hold_hilo", {hi_out, lo_out}, {32'd0, 32'd12});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
